// File: rtl/tensor_product_arbiter.sv
// Round-robin arbiter sharing one tensor_product between NUM_REQ requesters, one transaction in flight.
// Latency: accept at T, operands issued at T+1, WAIT from T+2, rsp_valid at T+3+L (L = tensor_product compute).
// Backpressure: req_ready only in IDLE; tp operands held until each is accepted; response held until rsp_ready.
module tensor_product_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int A_WIDTH      = 40,
  parameter int B_WIDTH      = 40,
  parameter int RESULT_WIDTH = 200,
  parameter int ID_WIDTH     = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [RESULT_WIDTH-1:0]    rsp_result,
  output logic                       rsp_error,
  output logic [NUM_REQ-1:0]         rsp_valid,
  input  logic [NUM_REQ-1:0]         rsp_ready,
  output logic [A_WIDTH-1:0]         tp_a,
  output logic                       tp_a_valid,
  input  logic                       tp_a_ready,
  output logic [B_WIDTH-1:0]         tp_b,
  output logic                       tp_b_valid,
  input  logic                       tp_b_ready,
  input  logic [RESULT_WIDTH-1:0]    tp_result,
  input  logic                       tp_result_valid,
  output logic                       tp_result_ready,
  input  logic                       tp_error,
  output logic [ID_WIDTH-1:0]        grant_id,
  output logic                       busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state;
  logic [ID_WIDTH-1:0] last_grant;
  logic [ID_WIDTH-1:0] sel_id;
  logic                sel_found;
  logic                a_sent;
  logic                b_sent;
  logic                a_done;
  logic                b_done;
  logic                rsp_hs;
  logic [A_WIDTH-1:0]  a_q;
  logic [B_WIDTH-1:0]  b_q;
  int unsigned         idx;

  // Round-robin pick: first valid requester after the last one served, wrapping around.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!sel_found && req_valid[idx]) begin
        sel_found = 1'b1;
        sel_id    = ID_WIDTH'(idx);
      end
    end
  end

  // Per-requester handshake vectors; req_ready is masked during reset so all outputs read zero.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = !rst && (state == IDLE) && sel_found && (sel_id == ID_WIDTH'(i));
      rsp_valid[i] = (state == RESP) && (grant_id == ID_WIDTH'(i));
    end
  end

  assign tp_a            = a_q;
  assign tp_b            = b_q;
  assign tp_a_valid      = (state == ISSUE) && !a_sent;
  assign tp_b_valid      = (state == ISSUE) && !b_sent;
  assign tp_result_ready = (state == WAIT);
  assign busy            = (state != IDLE);
  assign a_done          = a_sent || (tp_a_valid && tp_a_ready);
  assign b_done          = b_sent || (tp_b_valid && tp_b_ready);
  assign rsp_hs          = |(rsp_valid & rsp_ready);

  // Transaction sequencer: accept, issue both operands, capture result+error, return response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= ID_WIDTH'(NUM_REQ - 1);
      grant_id   <= ID_WIDTH'(NUM_REQ - 1);
      a_sent     <= 1'b0;
      b_sent     <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_result <= '0;
      rsp_error  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            a_q      <= req_a[sel_id*A_WIDTH +: A_WIDTH];
            b_q      <= req_b[sel_id*B_WIDTH +: B_WIDTH];
            grant_id <= sel_id;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          // Each operand is offered until its own handshake, never re-issued afterwards.
          if (a_done && b_done) begin
            a_sent <= 1'b0;
            b_sent <= 1'b0;
            state  <= WAIT;
          end else begin
            a_sent <= a_done;
            b_sent <= b_done;
          end
        end
        WAIT: begin
          // Error must be sampled with the result; tensor_product drops it once it goes idle.
          if (tp_result_valid) begin
            rsp_result <= tp_result;
            rsp_error  <= tp_error;
            state      <= RESP;
          end
        end
        RESP: begin
          if (rsp_hs) begin
            last_grant <= grant_id;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tensor_product_arbiter.sv
// Bench for tensor_product_arbiter: directed vectors, scoreboard queue checked by a response monitor.
// Includes a small behavioural tensor_product (5x5 outer product of signed Q4 8-bit cells, saturating).
// Downstream b-ready delay and compute latency are adjustable per test.
module tb_tensor_product_arbiter;

  localparam int NR = 2;
  localparam int AW = 40;
  localparam int BW = 40;
  localparam int RW = 200;
  localparam int IW = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR*AW-1:0] req_a;
  logic [NR*BW-1:0] req_b;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [RW-1:0]    rsp_result;
  logic             rsp_error;
  logic [NR-1:0]    rsp_valid;
  logic [NR-1:0]    rsp_ready;
  logic [AW-1:0]    tp_a;
  logic             tp_a_valid;
  logic             tp_a_ready;
  logic [BW-1:0]    tp_b;
  logic             tp_b_valid;
  logic             tp_b_ready;
  logic [RW-1:0]    tp_result;
  logic             tp_result_valid;
  logic             tp_result_ready;
  logic             tp_error;
  logic [IW-1:0]    grant_id;
  logic             busy;

  tensor_product_arbiter #(
    .NUM_REQ(NR), .A_WIDTH(AW), .B_WIDTH(BW), .RESULT_WIDTH(RW), .ID_WIDTH(IW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b), .req_valid(req_valid), .req_ready(req_ready),
    .rsp_result(rsp_result), .rsp_error(rsp_error), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .tp_a(tp_a), .tp_a_valid(tp_a_valid), .tp_a_ready(tp_a_ready),
    .tp_b(tp_b), .tp_b_valid(tp_b_valid), .tp_b_ready(tp_b_ready),
    .tp_result(tp_result), .tp_result_valid(tp_result_valid), .tp_result_ready(tp_result_ready),
    .tp_error(tp_error), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] a; logic [BW-1:0] b; } req_t;
  typedef struct { int id; logic [RW-1:0] res; logic err; } exp_t;

  req_t rq0[$];
  req_t rq1[$];
  exp_t exp_q[$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
  endtask

  function automatic logic [AW-1:0] fill5(input logic [7:0] c);
    return {5{c}};
  endfunction

  function automatic logic [RW-1:0] fill25(input logic [7:0] c);
    return {25{c}};
  endfunction

  // ---------------- behavioural tensor_product ----------------
  logic          got_a, got_b, res_vld, err_m;
  logic [AW-1:0] a_m;
  logic [BW-1:0] b_m;
  logic [RW-1:0] res_m;
  int            cnt, b_wait;
  int            b_delay = 0;
  int            tp_lat  = 2;
  logic [RW-1:0] calc_r;
  logic          calc_e;

  function automatic void tp_calc(input logic [AW-1:0] a, input logic [BW-1:0] b,
                                  output logic [RW-1:0] r, output logic e);
    logic signed [15:0] p;
    r = '0;
    e = 1'b0;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        p = $signed(a[i*8 +: 8]) * $signed(b[j*8 +: 8]);
        p = p >>> 4;
        if (p > 16'sd127) begin
          r[(i*5+j)*8 +: 8] = 8'h7f; e = 1'b1;
        end else if (p < -16'sd128) begin
          r[(i*5+j)*8 +: 8] = 8'h80; e = 1'b1;
        end else begin
          r[(i*5+j)*8 +: 8] = p[7:0];
        end
      end
    end
  endfunction

  assign tp_a_ready      = !got_a;
  assign tp_b_ready      = !got_b && (b_wait >= b_delay);
  assign tp_result       = res_m;
  assign tp_result_valid = res_vld;
  assign tp_error        = err_m;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      got_a <= 0; got_b <= 0; res_vld <= 0; err_m <= 0;
      a_m <= '0; b_m <= '0; res_m <= '0; cnt <= 0; b_wait <= 0;
    end else begin
      if (tp_a_valid && tp_a_ready) begin a_m <= tp_a; got_a <= 1; end
      if (tp_b_valid && tp_b_ready) begin b_m <= tp_b; got_b <= 1; b_wait <= 0; end
      else if (tp_b_valid) b_wait <= b_wait + 1;
      if (res_vld) begin
        if (tp_result_ready) begin
          res_vld <= 0; got_a <= 0; got_b <= 0; err_m <= 0;
        end
      end else if (got_a && got_b) begin
        if (cnt >= tp_lat - 1) begin
          tp_calc(a_m, b_m, calc_r, calc_e);
          res_m <= calc_r; err_m <= calc_e; res_vld <= 1; cnt <= 0;
        end else cnt <= cnt + 1;
      end
    end
  end

  // ---------------- requester driver ----------------
  logic acc0, acc1;
  always begin
    @(negedge clk);
    acc0 = req_valid[0] && req_ready[0];
    acc1 = req_valid[1] && req_ready[1];
    @(posedge clk);
    #1;
    if (acc0) void'(rq0.pop_front());
    if (acc1) void'(rq1.pop_front());
    req_valid[0] = (rq0.size() > 0);
    req_valid[1] = (rq1.size() > 0);
    if (rq0.size() > 0) begin req_a[0 +: AW] = rq0[0].a; req_b[0 +: BW] = rq0[0].b; end
    if (rq1.size() > 0) begin req_a[AW +: AW] = rq1[0].a; req_b[BW +: BW] = rq1[0].b; end
  end

  // ---------------- monitor / scoreboard ----------------
  int   a_vld_cyc, b_vld_cyc, a_acc, early_wait, rr0_cyc;
  exp_t mon_e;
  int   mon_id;

  always @(negedge clk) begin
    if (!rst) begin
      a_vld_cyc  += int'(tp_a_valid);
      b_vld_cyc  += int'(tp_b_valid);
      a_acc      += int'(tp_a_valid && tp_a_ready);
      early_wait += int'(tp_result_ready && !(got_a && got_b));
      rr0_cyc    += int'(req_ready[0]);
      chk("req_ready_legal", ((req_ready & ~req_valid) == 0) && !(busy && req_ready != 0), 1);
      if (|(rsp_valid & rsp_ready)) begin
        if (exp_q.size() == 0) chk("unexpected_rsp", rsp_valid, 0);
        else begin
          mon_e  = exp_q.pop_front();
          mon_id = (rsp_valid == 2'b01) ? 0 : (rsp_valid == 2'b10) ? 1 : 9;
          chk("rsp_id", mon_id, mon_e.id);
          chk("grant_id", grant_id, mon_e.id);
          chk("rsp_result", rsp_result, mon_e.res);
          chk("rsp_error", rsp_error, mon_e.err);
        end
      end
    end
  end

  task automatic clr_counters();
    a_vld_cyc = 0; b_vld_cyc = 0; a_acc = 0; early_wait = 0; rr0_cyc = 0;
  endtask

  task automatic push(input int id, input logic [AW-1:0] a, input logic [BW-1:0] b,
                      input logic [RW-1:0] res, input logic err);
    req_t r;
    exp_t e;
    r.a = a; r.b = b;
    e.id = id; e.res = res; e.err = err;
    if (id == 0) rq0.push_back(r); else rq1.push_back(r);
    exp_q.push_back(e);
  endtask

  task automatic drain(input string nm, input int maxc);
    int c = 0;
    while ((exp_q.size() != 0 || rq0.size() != 0 || rq1.size() != 0 || busy) && c < maxc) begin
      @(negedge clk);
      c++;
    end
    chk(nm, c < maxc, 1);
    @(posedge clk);
    #1;
  endtask

  // what: 0 = rsp_valid[1], 1 = tp_result_ready (arbiter in WAIT)
  task automatic wait_for(input int what, input int maxc, input string nm);
    int   c = 0;
    logic hit = 1'b0;
    while (!hit && c < maxc) begin
      @(negedge clk);
      c++;
      hit = (what == 0) ? rsp_valid[1] : tp_result_ready;
    end
    chk(nm, hit, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_tp_valids"}, {tp_a_valid, tp_b_valid, tp_result_ready}, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rsp_data"}, {rsp_error, rsp_result}, 0);
    chk({tag, "_tp_ops"}, {tp_a, tp_b}, 0);
    chk({tag, "_grant_id"}, grant_id, NR - 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 2'b11;
    clr_counters();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // 1: single request from requester 0, 1.0 x 2.0 -> every cell 2.0
    clr_counters();
    push(0, fill5(8'd16), fill5(8'd32), fill25(8'd32), 1'b0);
    drain("t1_drain", 100);
    chk("t1_req_ready_cycles", rr0_cyc, 1);
    chk("t1_grant_id", grant_id, 0);

    // 2: both continuously valid after reset -> grants 0,1,0,1
    rst = 1'b1; #2; rst = 1'b0;
    push(0, fill5(8'd16), fill5(8'd16), fill25(8'd16), 1'b0);
    push(1, fill5(8'd32), fill5(8'd32), fill25(8'd64), 1'b0);
    push(0, fill5(8'd16), fill5(8'd16), fill25(8'd16), 1'b0);
    push(1, fill5(8'd32), fill5(8'd32), fill25(8'd64), 1'b0);
    drain("t2_drain", 200);

    // 3: b accepted only in its third offered cycle; a must go out exactly once
    b_delay = 2;
    clr_counters();
    push(0, fill5(8'd16), 40'h0504030201, {5{40'h0504030201}}, 1'b0);
    drain("t3_drain", 100);
    chk("t3_a_valid_cycles", a_vld_cyc, 1);
    chk("t3_b_valid_cycles", b_vld_cyc, 3);
    chk("t3_a_accepts", a_acc, 1);
    chk("t3_early_wait", early_wait, 0);
    b_delay = 0;

    // 4: overflow, error must survive tensor_product going idle
    rsp_ready = 2'b01;
    push(1, fill5(8'd127), fill5(8'd127), fill25(8'h7f), 1'b1);
    wait_for(0, 100, "t4_rsp_seen");
    repeat (3) @(negedge clk);
    chk("t4_tp_error_cleared", tp_error, 0);
    chk("t4_rsp_error_held", rsp_error, 1);
    chk("t4_rsp_valid_held", rsp_valid, 2'b10);
    @(posedge clk); #1;
    rsp_ready = 2'b11;
    drain("t4_drain", 100);

    // 5: response backpressure on requester 1 while requester 0 waits
    rsp_ready = 2'b01;
    push(1, fill5(8'd16), fill5(8'd48), fill25(8'd48), 1'b0);
    wait_for(0, 100, "t5_rsp_seen");
    push(0, fill5(8'd32), fill5(8'd16), fill25(8'd32), 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t5_rsp_valid", rsp_valid, 2'b10);
      chk("t5_rsp_result", rsp_result, fill25(8'd48));
      chk("t5_req_ready", req_ready, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 2'b11;
    drain("t5_drain", 100);

    // 6: async reset in the middle of WAIT, between clock edges
    tp_lat = 20;
    begin
      req_t r;
      r.a = fill5(8'd16); r.b = fill5(8'd16);
      rq1.push_back(r);
    end
    wait_for(1, 100, "t6_in_wait");
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("t6_mid_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    tp_lat = 2;
    push(0, fill5(8'd16), fill5(8'd32), fill25(8'd32), 1'b0);
    push(1, fill5(8'd32), fill5(8'd16), fill25(8'd32), 1'b0);
    drain("t6_drain", 200);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tensor_product_arbiter.md
Name: tensor_product_arbiter

Overview:
Round-robin arbiter that shares one tensor_product instance between NUM_REQ requesters. Typical requesters are per-layer weight-update units in the backpropagation path. Each request carries a full operand pair (a, b). The arbiter issues the pair to the shared tensor_product, captures its result and overflow flag, and returns both to the granted requester over a valid/ready response channel. Only one transaction is in flight at a time.

Parameters:
NUM_REQ, 2, number of requesters (>=1)
A_WIDTH, 40, flattened width of operand a (A_VECTOR_LEN*A_CELL_WIDTH of the shared tensor_product)
B_WIDTH, 40, flattened width of operand b
RESULT_WIDTH, 200, flattened width of tensor_product result
ID_WIDTH, 1, width of grant index; must satisfy 2**ID_WIDTH >= NUM_REQ

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
req_a  in  NUM_REQ*A_WIDTH  operand a per requester; slot i at [i*A_WIDTH+:A_WIDTH]
req_b  in  NUM_REQ*B_WIDTH  operand b per requester; same slicing
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester request accept (one-hot or zero)
rsp_result  out  RESULT_WIDTH  captured result, broadcast to all requesters
rsp_error  out  1  captured overflow flag, broadcast
rsp_valid  out  NUM_REQ  response valid, one-hot to the granted requester
rsp_ready  in  NUM_REQ  per-requester response accept
tp_a  out  A_WIDTH  to tensor_product a
tp_a_valid  out  1  to tensor_product a_valid
tp_a_ready  in  1  from tensor_product a_ready
tp_b  out  B_WIDTH  to tensor_product b
tp_b_valid  out  1  to tensor_product b_valid
tp_b_ready  in  1  from tensor_product b_ready
tp_result  in  RESULT_WIDTH  from tensor_product result
tp_result_valid  in  1  from tensor_product result_valid
tp_result_ready  out  1  to tensor_product result_ready
tp_error  in  1  from tensor_product error
grant_id  out  ID_WIDTH  index of the current or last granted requester
busy  out  1  high when state != IDLE

Behaviour:
- Reset (async): state=IDLE, last_grant=NUM_REQ-1, a_sent=b_sent=0. All data registers 0. All outputs 0 except grant_id=NUM_REQ-1.
- States: IDLE, ISSUE, WAIT, RESP. Encodings outside these return to IDLE.
- IDLE:
  - sel = first i with req_valid[i], searching from (last_grant+1) mod NUM_REQ upward with wrap-around.
  - req_ready[sel]=1 combinationally while any req_valid is high; the handshake completes that cycle.
  - On handshake: latch req_a/req_b slot sel, set grant_id<=sel, go to ISSUE.
  - No valid request: stay in IDLE, req_ready=0.
- ISSUE:
  - tp_a_valid = !a_sent and tp_b_valid = !b_sent; tp_a and tp_b are driven from the latched registers.
  - a_sent sets on tp_a_valid&&tp_a_ready; b_sent likewise.
  - When both are sent (including both in the same cycle), go to WAIT and clear the flags.
- WAIT:
  - tp_result_ready=1.
  - On tp_result_valid: latch tp_result into rsp_result and tp_error into rsp_error in the same cycle. The error must be captured then because tensor_product clears it on its return to IDLE. Go to RESP.
- RESP:
  - rsp_valid[grant_id]=1, held until rsp_ready[grant_id].
  - On that handshake: last_grant<=grant_id, go to IDLE.
  - rsp_result and rsp_error stay stable until the next WAIT capture.
- tp_result_ready=0 outside WAIT. tp_result_valid outside WAIT is ignored.
- req_ready=0 outside IDLE. Requests must hold valid and data until accepted; deassertion before acceptance is legal and simply forfeits the turn.
- Fairness: a requester that stays valid is granted within NUM_REQ transactions.
- Minimum latency, request accept (cycle T) to rsp_valid:
  - ISSUE at T+1, with tp handshakes at T+1.
  - WAIT from T+2 until tp_result_valid at T+2+L, where L is tensor_product compute time.
  - RESP at T+3+L.
  - Back-to-back accept earliest one cycle after the rsp handshake.
- NUM_REQ=1: the arbiter degenerates to a sequencer; grant_id is always 0.
- rst mid-transaction aborts immediately; the shared tensor_product is on the same rst, so no half-issued operands remain.

Test Plan:
1. Single request, NUM_REQ=2: req_valid=2'b01, a=5 cells of 16 (1.0, FRACTION_WIDTH=4), b=5 cells of 32 (2.0) -> req_ready=2'b01 for one cycle; rsp_valid=2'b01 with all 25 result cells=32 (2.0); rsp_error=0; grant_id=0.
2. Round-robin: both requesters continuously valid for 4 transactions -> grant order 0,1,0,1; never the same requester twice while the other waits.
3. Staggered downstream readiness: tp_a_ready high, tp_b_ready delayed 3 cycles -> tp_a_valid drops after one cycle, tp_b_valid holds 3 cycles, WAIT is entered only after both are accepted, and tp_a is never re-issued.
4. Overflow: a cells=127, b cells=127 (8-bit cells) -> rsp_error=1, still 1 after tensor_product returns to IDLE, and held until the rsp handshake.
5. Response backpressure: rsp_ready[1]=0 for 10 cycles -> rsp_valid=2'b10 and rsp_result held stable; req_ready stays 0 for requester 0 throughout.
6. Async reset asserted mid-WAIT, between clock edges -> all outputs 0 immediately and grant_id=NUM_REQ-1; after release, the first grant goes to requester 0.
